sd_mod_multi: RTL and testbench



---
 rtl/sd_pkg.sv | 40 ++++
 rtl/sd_sat_integrator.sv | 43 ++++
 rtl/sd_mod_multi.sv | 144 ++++++++++++++
 tb/tb_sd_mod_multi.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and saturation helpers for the sd_mod_multi sigma-delta modulator.
package sd_pkg;

    typedef enum logic {
        SD_ORDER1 = 1'b0,
        SD_ORDER2 = 1'b1
    } sd_order_e;

    localparam int SD_WIDE = 128;
    typedef logic signed [SD_WIDE-1:0] sd_wide_t;

    function automatic sd_wide_t sd_maxpos(input int w);
        return (sd_wide_t'(1) <<< (w - 1)) - sd_wide_t'(1);
    endfunction

    function automatic sd_wide_t sd_maxneg(input int w);
        return -sd_maxpos(w) - sd_wide_t'(1);
    endfunction

    function automatic sd_wide_t sd_fb(input int shift);
        return sd_wide_t'(1) <<< shift;
    endfunction

    function automatic sd_wide_t sd_sat(input sd_wide_t x, input int w);
        if (x > sd_maxpos(w)) begin
            return sd_maxpos(w);
        end
        if (x < sd_maxneg(w)) begin
            return sd_maxneg(w);
        end
        return x;
    endfunction

    // a + b - c evaluated wide enough that it can never wrap, then clamped
    function automatic sd_wide_t sd_sat_add(input sd_wide_t a, input sd_wide_t b,
                                            input sd_wide_t c, input int w);
        return sd_sat(a + b - c, w);
    endfunction

endpackage

// File: rtl/sd_sat_integrator.sv
// Clamped accumulator: acc <= sat(acc + inc - fb) with enable, clear and saturation flag.
module sd_sat_integrator
    import sd_pkg::*;
#(
    parameter int                          BITWIDTH = 40,
    parameter logic signed [BITWIDTH-1:0]  RESETVAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en_i,
    input  logic                       clr_i,
    input  logic signed [BITWIDTH-1:0] inc_i,
    input  logic signed [BITWIDTH-1:0] fb_i,
    output logic signed [BITWIDTH-1:0] q_o,
    output logic signed [BITWIDTH-1:0] nx_o,
    output logic                       sat_o
);

    logic signed [BITWIDTH-1:0] acc_q;
    sd_wide_t                   raw;
    sd_wide_t                   clamped;

    always_comb begin
        raw     = sd_wide_t'(acc_q) + sd_wide_t'(inc_i) - sd_wide_t'(fb_i);
        clamped = sd_sat_add(sd_wide_t'(acc_q), sd_wide_t'(inc_i),
                             sd_wide_t'(fb_i), BITWIDTH);
    end

    assign nx_o  = clamped[BITWIDTH-1:0];
    assign sat_o = (clamped != raw);
    assign q_o   = acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= RESETVAL;
        end else if (clr_i) begin
            acc_q <= RESETVAL;
        end else if (en_i) begin
            acc_q <= nx_o;
        end
    end

endmodule

// File: rtl/sd_mod_multi.sv
// First/second-order sigma-delta modulator with coefficient bank and sticky saturation.
// Define SD_OVL_RECOVER_EN to clear the integrators after OVL_LIMIT saturated cycles.
module sd_mod_multi
    import sd_pkg::*;
#(
    parameter int                          BITWIDTH  = 40,
    parameter int                          NCOEF     = 4,
    parameter int                          FB_SHIFT  = 16,
    parameter logic signed [BITWIDTH-1:0]  RESETVAL  = '0,
    parameter int                          OVL_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       order_sel,
    input  logic [$clog2(NCOEF)-1:0]   sel,
    input  logic                       coef_wr_en,
    input  logic [$clog2(NCOEF)-1:0]   coef_wr_addr,
    input  logic signed [BITWIDTH-1:0] coef_wr_data,
    input  logic                       sat_clr,
    output logic                       bs_out,
    output logic                       sat_flag,
    output logic                       ovl_event
);

    localparam int SW = $clog2(NCOEF);
    localparam logic signed [BITWIDTH-1:0] F = BITWIDTH'(sd_fb(FB_SHIFT));

    logic signed [BITWIDTH-1:0] coef_q [NCOEF];
    logic [SW-1:0]              sel_q;
    sd_order_e                  order_q;
    logic                       bs_q, bs_d;
    logic                       satf_q, satf_d;

    logic signed [BITWIDTH-1:0] k, fb;
    logic signed [BITWIDTH-1:0] i1_q, i2_q, i1_nx, i2_nx;
    logic                       s1, s2, sat_any;
    logic                       mismatch, ovl_fire, clr, i2_en;

    assign k        = coef_q[sel_q];
    assign fb       = bs_q ? F : -F;
    assign mismatch = (order_q != sd_order_e'(order_sel));
    assign clr      = mismatch | ovl_fire;
    assign i2_en    = en & (order_q == SD_ORDER2);
    assign sat_any  = (en & s1) | (i2_en & s2);

    sd_sat_integrator #(.BITWIDTH(BITWIDTH), .RESETVAL(RESETVAL)) u_i1 (
        .clk   (clk),
        .reset (reset),
        .en_i  (en),
        .clr_i (clr),
        .inc_i (k),
        .fb_i  (fb),
        .q_o   (i1_q),
        .nx_o  (i1_nx),
        .sat_o (s1)
    );

    sd_sat_integrator #(.BITWIDTH(BITWIDTH), .RESETVAL(RESETVAL)) u_i2 (
        .clk   (clk),
        .reset (reset),
        .en_i  (i2_en),
        .clr_i (clr),
        .inc_i (i1_q),
        .fb_i  (fb),
        .q_o   (i2_q),
        .nx_o  (i2_nx),
        .sat_o (s2)
    );

    always_comb begin
        bs_d   = bs_q;
        satf_d = satf_q;
        if (clr) begin
            bs_d = 1'b0;
        end else if (en) begin
            bs_d = (order_q == SD_ORDER2) ? ~i2_nx[BITWIDTH-1]
                                          : ~i1_nx[BITWIDTH-1];
        end
        // a clamp discarded by a clear never reaches the integrators
        if (sat_any && !clr) begin
            satf_d = 1'b1;
        end else if (sat_clr) begin
            satf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCOEF; i++) begin
                coef_q[i] <= '0;
            end
            sel_q   <= '0;
            order_q <= SD_ORDER1;
            bs_q    <= 1'b0;
            satf_q  <= 1'b0;
        end else begin
            if (coef_wr_en) begin
                coef_q[coef_wr_addr] <= coef_wr_data;
            end
            sel_q   <= sel;
            order_q <= sd_order_e'(order_sel);
            bs_q    <= bs_d;
            satf_q  <= satf_d;
        end
    end

`ifdef SD_OVL_RECOVER_EN
    localparam int CW = $clog2(OVL_LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovl_q;

    assign ovl_fire = (cnt_q == CW'(OVL_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = sat_any ? cnt_q + CW'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovl_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovl_q <= ovl_fire;
        end
    end

    assign ovl_event = ovl_q;
`else
    assign ovl_fire  = 1'b0;
    assign ovl_event = 1'b0;
`endif

    assign bs_out   = bs_q;
    assign sat_flag = satf_q;

endmodule

// File: tb/tb_sd_mod_multi.sv
// Scoreboard bench for sd_mod_multi: directed phases plus random stimulus vs a reference model.
module tb_sd_mod_multi;

    localparam int     BW   = 40;
    localparam int     NC   = 4;
    localparam int     FBS  = 16;
    localparam int     LIM  = 8;
    localparam longint F    = 64'sd1 <<< FBS;
    localparam longint MAXP = (64'sd1 <<< (BW - 1)) - 64'sd1;
    localparam longint MAXN = -MAXP - 64'sd1;
`ifdef SD_OVL_RECOVER_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset, en, order_sel, coef_wr_en, sat_clr;
    logic [1:0]           sel, coef_wr_addr;
    logic signed [BW-1:0] coef_wr_data;
    logic                 bs_out, sat_flag, ovl_event;

    sd_mod_multi #(
        .BITWIDTH (BW),
        .NCOEF    (NC),
        .FB_SHIFT (FBS),
        .RESETVAL ('0),
        .OVL_LIMIT(LIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .order_sel   (order_sel),
        .sel         (sel),
        .coef_wr_en  (coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .sat_clr     (sat_clr),
        .bs_out      (bs_out),
        .sat_flag    (sat_flag),
        .ovl_event   (ovl_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   bs;
        logic   sf;
        logic   ov;
        longint i1;
        longint i2;
    } exp_t;

    exp_t   sbq[$];
    int     ncmp = 0;
    int     nerr = 0;

    longint m_coef[NC];
    int     m_sel, m_cnt;
    bit     m_ord, m_bs, m_sf, m_ov;
    longint m_i1, m_i2;

    function automatic void chk(string nm, longint act, longint exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk_rng(string nm, longint act, longint lo, longint hi);
        ncmp++;
        if (act < lo || act > hi) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endfunction

    function automatic longint clampv(longint x);
        if (x > MAXP) return MAXP;
        if (x < MAXN) return MAXN;
        return x;
    endfunction

    // One clock edge of the modulator, computed from the behavioural rules
    function automatic void model_step();
        longint k, fb, s1, s2, c1, c2;
        bit     sat, clr, ovf;
        if (reset) begin
            foreach (m_coef[i]) m_coef[i] = 0;
            m_sel = 0; m_ord = 0; m_bs = 0; m_sf = 0; m_ov = 0;
            m_i1 = 0; m_i2 = 0; m_cnt = 0;
            return;
        end
        k   = m_coef[m_sel];
        fb  = m_bs ? F : -F;
        ovf = OVL && (m_cnt == LIM);
        clr = (order_sel != m_ord) || ovf;
        s1  = m_i1 + k - fb;
        s2  = m_i2 + m_i1 - fb;
        c1  = clampv(s1);
        c2  = clampv(s2);
        sat = en && ((c1 != s1) || (m_ord && (c2 != s2)));
        if (sat && !clr) m_sf = 1;
        else if (sat_clr) m_sf = 0;
        if (clr) begin
            m_i1 = 0; m_i2 = 0; m_bs = 0; m_cnt = 0;
        end else if (en) begin
            m_i1 = c1;
            if (m_ord) m_i2 = c2;
            m_bs  = m_ord ? (c2 >= 0) : (c1 >= 0);
            m_cnt = sat ? m_cnt + 1 : 0;
        end
        m_ov = ovf;
        if (coef_wr_en) m_coef[coef_wr_addr] = longint'(coef_wr_data);
        m_sel = int'(sel);
        m_ord = order_sel;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.bs = m_bs; e.sf = m_sf; e.ov = m_ov; e.i1 = m_i1; e.i2 = m_i2;
        sbq.push_back(e);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input longint v);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = v[BW-1:0];
        tick();
        coef_wr_en   = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("bs_out", longint'(bs_out), longint'(e.bs));
            chk("sat_flag", longint'(sat_flag), longint'(e.sf));
            chk("ovl_event", longint'(ovl_event), longint'(e.ov));
            chk("i1", longint'(dut.i1_q), e.i1);
            chk("i2", longint'(dut.i2_q), e.i2);
        end
    end

    initial begin
        int          ones, nov;
        int          pat[6];
        logic        hb;
        longint      hi1;
        logic [63:0] r64;
        pat = '{1, 1, 0, 1, 0, 1};

        reset = 1'b1; en = 1'b0; order_sel = 1'b0; sel = '0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; sat_clr = 1'b0;
        repeat (2) tick();
        chk("rst_bs", longint'(bs_out), 0);
        chk("rst_sf", longint'(sat_flag), 0);
        chk("rst_ovl", longint'(ovl_event), 0);
        chk("rst_i1", longint'(dut.i1_q), 0);
        chk("rst_i2", longint'(dut.i2_q), 0);

        reset = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("half_pat", longint'(bs_out), pat[i]);
        end

        wr(2'd2, 32768);
        sel = 2'd2;
        repeat (8) tick();
        ones = 0;
        repeat (1024) begin
            tick();
            ones += int'(bs_out);
        end
        chk_rng("dens_3q", ones, 766, 770);

        order_sel = 1'b1;
        wr(2'd3, -32768);
        sel = 2'd3;
        repeat (32) tick();
        ones = 0;
        repeat (1024) begin
            tick();
            ones += int'(bs_out);
        end
        chk_rng("dens_1q_o2", ones, 252, 260);

        order_sel = 1'b0;
        tick();
        chk("ord_i1", longint'(dut.i1_q), 0);
        chk("ord_i2", longint'(dut.i2_q), 0);
        chk("ord_bs", longint'(bs_out), 0);

        sel = 2'd2;
        repeat (9) tick();
        en  = 1'b0;
        hb  = bs_out;
        hi1 = longint'(dut.i1_q);
        wr(2'd2, -20000);
        chk("hold_bs", longint'(bs_out), longint'(hb));
        chk("hold_i1", longint'(dut.i1_q), hi1);
        repeat (9) begin
            tick();
            chk("hold_bs", longint'(bs_out), longint'(hb));
            chk("hold_i1", longint'(dut.i1_q), hi1);
        end
        en = 1'b1;
        repeat (20) tick();

        wr(2'd1, MAXP);
        sel     = 2'd1;
        sat_clr = 1'b1;
        nov     = 0;
        repeat (40) begin
            tick();
            if (ovl_event) begin
                nov++;
                chk("ovl_i1", longint'(dut.i1_q), 0);
            end
        end
        chk("ovl_seen", longint'(nov > 0), longint'(OVL));
        sat_clr = 1'b0;
        repeat (5) tick();

        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(299) == 0);
            en         = ($urandom_range(9) < 8);
            if ($urandom_range(99) == 0) order_sel = ~order_sel;
            sel        = 2'($urandom_range(3));
            sat_clr    = ($urandom_range(9) == 0);
            coef_wr_en = ($urandom_range(7) == 0);
            coef_wr_addr = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) begin
                r64 = {$urandom, $urandom};
                coef_wr_data = r64[BW-1:0];
            end else begin
                coef_wr_data = BW'(longint'($urandom_range(200000)) - 100000);
            end
            tick();
        end
        reset = 1'b0; coef_wr_en = 1'b0;

        @(negedge clk);
        #1;
        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
